// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer: computes a - b one bit per clock, LSB first,
// through a single borrow-chained subtractor cell framed by a start/busy/done handshake.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             x, y, d, bout, last_bit;
  logic [WIDTH:0]   res_shift;

  // Subtractor cell: two cascaded half-subtractors with their borrows ORed.
  always_comb begin
    x         = a_sr[0];
    y         = b_sr[0];
    d         = x ^ y ^ bin;
    bout      = (~x & y) | (~(x ^ y) & bin);
    last_bit  = (cnt == LAST);
    // Widened by one bit so the MSB insert stays a legal slice when WIDTH is 1.
    res_shift = {d, res_sr};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_next unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // NOTE: reset is synchronous and clears the shift registers too, so a
  // discarded operation leaves no residue in the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            cnt  <= '0;
            bin  <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift[WIDTH:1];
          bin    <= bout;
          cnt    <= cnt + CW'(1);
          // Outputs update only on completion so partial results stay hidden.
          if (last_bit) begin
            difference <= res_shift[WIDTH:1];
            borrow_out <= bout;
            done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed handshake/reset scenarios at
// WIDTH=8 plus randomized regressions at WIDTH=1 and WIDTH=16 against an arithmetic model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8,  busy8,  done8,  borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        start1,  busy1,  done1,  borrow1;
  logic [0:0]  a1, b1, diff1;
  logic        start16, busy16, done16, borrow16;
  logic [15:0] a16, b16, diff16;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .difference(diff8), .borrow_out(borrow8)
  );
  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .difference(diff1), .borrow_out(borrow1)
  );
  serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .difference(diff16), .borrow_out(borrow16)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: modular difference and unsigned less-than.
  function automatic logic [31:0] ref_diff(input longint unsigned av, input longint unsigned bv,
                                           input int w);
    longint unsigned m;
    m = longint'(1) << w;
    return 32'((av + m - bv) % m);
  endfunction

  function automatic logic [31:0] ref_borrow(input longint unsigned av, input longint unsigned bv);
    return (av < bv) ? 32'd1 : 32'd0;
  endfunction

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat, output int bcy);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = 0; bcy = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bcy++;
      tick;
      lat++;
    end
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv, output int lat);
    a1 = av; b1 = bv; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, output int lat);
    a16 = av; b16 = bv; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 60) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat, bcy;
    logic seen_done;
    logic [31:0] ra, rb;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    tick; tick;
    rst = 1'b0;

    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_borrow8", borrow8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_diff16", diff16, 0);

    // Basic operation, latency and busy width.
    op8(8'h5A, 8'h3C, lat, bcy);
    check("basic_lat", lat, 8);
    check("basic_busy_cycles", bcy, 8);
    check("basic_busy_at_done", busy8, 0);
    check("basic_diff", diff8, 8'h1E);
    check("basic_borrow", borrow8, 0);
    tick;
    check("basic_done_one_cycle", done8, 0);
    check("basic_diff_hold", diff8, 8'h1E);

    op8(8'h00, 8'h01, lat, bcy);
    check("under_diff", diff8, 8'hFF);
    check("under_borrow", borrow8, 1);
    op8(8'hA5, 8'hA5, lat, bcy);
    check("equal_diff", diff8, 8'h00);
    check("equal_borrow", borrow8, 0);

    // start held high with operands changing during RUN.
    tick;
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    tick;
    check("held_accept_busy", busy8, 1);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick;
      lat++;
    end
    check("held_lat", lat, 8);
    check("held_diff", diff8, 8'hEF);
    check("held_borrow", borrow8, 1);
    a8 = 8'h80; b8 = 8'h7F;
    tick;
    check("held_reaccept_busy", busy8, 1);
    check("held_reaccept_done", done8, 0);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick;
      lat++;
    end
    check("held2_lat", lat, 8);
    check("held2_diff", diff8, 8'h01);
    check("held2_borrow", borrow8, 0);

    // Back-to-back: second start issued in the done cycle.
    tick;
    op8(8'h10, 8'h20, lat, bcy);
    check("b2b1_diff", diff8, 8'hF0);
    check("b2b1_borrow", borrow8, 1);
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      check("b2b_hold_diff", diff8, 8'hF0);
      tick;
      lat++;
    end
    check("b2b2_lat", lat, 8);
    check("b2b2_diff", diff8, 8'hFE);
    check("b2b2_borrow", borrow8, 0);

    // Reset three cycles into an operation.
    tick;
    op8(8'h5A, 8'h3C, lat, bcy);
    check("pre_rst_diff", diff8, 8'h1E);
    tick;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_diff", diff8, 0);
    check("mid_rst_borrow", borrow8, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done8 !== 1'b0) seen_done = 1'b1;
    end
    check("mid_rst_no_done", seen_done, 0);

    // rst and start together: rst wins.
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0; start8 = 1'b0;
    check("rst_vs_start_busy", busy8, 0);
    tick;
    check("rst_vs_start_idle", busy8, 0);

    op8(8'h03, 8'h05, lat, bcy);
    check("post_rst_lat", lat, 8);
    check("post_rst_diff", diff8, 8'hFE);
    check("post_rst_borrow", borrow8, 1);

    // Random regression, WIDTH=1.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      op1(ra[0], rb[0], lat);
      check("w1_lat", lat, 1);
      check("w1_diff", diff1, ref_diff(ra & 32'h1, rb & 32'h1, 1));
      check("w1_borrow", borrow1, ref_borrow(ra & 32'h1, rb & 32'h1));
    end

    // Random regression, WIDTH=16, with some boundary operands mixed in.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFFFF; rb = $urandom & 32'hFFFF;
      case (i % 8)
        0: rb = ra;
        1: ra = 32'h0;
        2: rb = 32'hFFFF;
        default: ;
      endcase
      op16(ra[15:0], rb[15:0], lat);
      check("w16_lat", lat, 16);
      check("w16_diff", diff16, ref_diff(ra, rb, 16));
      check("w16_borrow", borrow16, ref_borrow(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
